dcache_responder: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache. It sits between the pipeline's memory stage and the backing data memory.
- It answers pipeline load/store requests on the CPU side and stalls the pipeline via cpu_ready while it runs refill or write-through transactions on the memory side.
- The memory side uses a req/ack handshake, so backing memory latency is arbitrary.

---
 rtl/dcache_responder.sv | 184 ++++++++++++++++++
 tb/tb_dcache_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between the memory stage and data memory.
// Optional load hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_responder #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_W    = ADDR_W - 2 - OFF_BITS - INDEX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

    state_t state, next_state;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES][LINE_WORDS];
    logic [OFF_BITS-1:0] refill_cnt;

    logic [OFF_BITS-1:0]   req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic                  ack;
    logic                  last_word;
    logic                  load_hit;
    logic                  load_miss;
    logic                  unused_byte_sel;

    assign req_off   = cpu_addr[2 +: OFF_BITS];
    assign req_idx   = cpu_addr[2+OFF_BITS +: INDEX_BITS];
    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ack       = mem_ack && mem_req;
    assign last_word = (refill_cnt == LAST_WORD);
    assign load_hit  = (state == IDLE) && cpu_req && !cpu_we && hit;
    assign load_miss = (state == IDLE) && cpu_req && !cpu_we && !hit;

    assign unused_byte_sel = ^cpu_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cpu_req && cpu_we) next_state = WRITE;
                else if (load_miss)    next_state = REFILL;
            end
            REFILL: if (ack && last_word) next_state = RESP;
            WRITE:  if (ack)              next_state = IDLE;
            RESP:                         next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    // Hits answer combinationally from IDLE; stores complete in the cycle memory acknowledges them.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = 32'h0;
        unique case (state)
            IDLE: begin
                if (load_hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_q[req_idx][req_off];
                end
            end
            RESP: begin
                if (cpu_req) begin
                    cpu_ready = 1'b1;
                    if (!cpu_we) cpu_rdata = data_q[req_idx][req_off];
                end
            end
            WRITE: begin
                if (cpu_req && ack) cpu_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            refill_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req && cpu_we) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        mem_be    <= cpu_be;
                    end else if (load_miss) begin
                        mem_req          <= 1'b1;
                        mem_we           <= 1'b0;
                        mem_addr         <= {cpu_addr[ADDR_W-1:2+OFF_BITS], OFF_BITS'(0), 2'b00};
                        mem_wdata        <= 32'h0;
                        mem_be           <= 4'h0;
                        refill_cnt       <= '0;
                        valid_q[req_idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (ack) begin
                        refill_cnt <= refill_cnt + OFF_BITS'(1);
                        if (last_word) begin
                            mem_req          <= 1'b0;
                            valid_q[req_idx] <= 1'b1;
                        end else begin
                            mem_addr <= {cpu_addr[ADDR_W-1:2+OFF_BITS], refill_cnt + OFF_BITS'(1), 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays need no reset: the valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (state == REFILL && ack) begin
            data_q[req_idx][refill_cnt] <= mem_rdata;
            if (last_word) tag_q[req_idx] <= req_tag;
        end
        if (state == WRITE && ack && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_be[b]) data_q[req_idx][req_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (load_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (load_miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = 32'h0;
    assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: expected CPU responses and memory transactions are queued
// by the stimulus and popped by a CPU-side monitor and a req/ack memory model with 2-cycle latency.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dcache_responder dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        is_load;
    } cpu_exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_exp_t;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    int          checks = 0;
    int          passes = 0;
    int          ack_count = 0;
    logic [31:0] mem_arr [0:4095];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic check_counters(input logic [31:0] hits, input logic [31:0] misses);
        check_output("hit_cnt",  hit_cnt,  STATS ? hits : 32'h0);
        check_output("miss_cnt", miss_cnt, STATS ? misses : 32'h0);
    endtask

    task automatic expect_refill(input logic [31:0] base);
        for (int w = 0; w < 4; w++) mem_q.push_back('{1'b0, base + 32'(4*w), 32'h0, 4'h0});
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input logic [31:0] exp_rdata, input int exp_cycles);
        int cycles;
        cpu_q.push_back('{addr, exp_rdata, !we});
        if (we) mem_q.push_back('{1'b1, {addr[31:2], 2'b00}, wdata, be});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!cpu_ready && cycles < 200);
        check_output($sformatf("ready before timeout @%h", addr), {31'b0, cpu_ready}, 32'h1);
        check_output($sformatf("cycles to ready @%h", addr), 32'(cycles), 32'(exp_cycles));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    // CPU-side monitor: every cpu_ready must match the oldest outstanding expectation.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    check_output("cpu_ready without request", {31'b0, cpu_ready}, 32'h0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_load) check_output($sformatf("load rdata @%h", e.addr), cpu_rdata, e.rdata);
                    else           check_output($sformatf("store ready with ack @%h", e.addr), {31'b0, mem_ack}, 32'h1);
                end
            end
        end
    end

    // Backing memory: acknowledges each request on the second cycle it is seen.
    initial begin
        int       wait_cnt;
        mem_exp_t e;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hD000_0000 | 32'(i << 2);
        mem_arr[16] = 32'h11;
        mem_arr[17] = 32'h22;
        mem_arr[18] = 32'h33;
        mem_arr[19] = 32'h44;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt == 1) begin
                wait_cnt = 0;
                ack_count++;
                if (mem_q.size() == 0) begin
                    check_output($sformatf("unexpected mem_req @%h", mem_addr), {31'b0, mem_req}, 32'h0);
                end else begin
                    e = mem_q.pop_front();
                    check_output("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    check_output("mem_addr", mem_addr, e.addr);
                    if (e.we) begin
                        check_output("mem_wdata", mem_wdata, e.wdata);
                        check_output("mem_be", {28'b0, mem_be}, {28'b0, e.be});
                    end
                end
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem_arr[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata = mem_arr[mem_addr[13:2]];
                end
                mem_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " cpu_ready"}, {31'b0, cpu_ready}, 32'h0);
        check_output({tag, " cpu_rdata"}, cpu_rdata, 32'h0);
        check_output({tag, " mem_req/we/be"}, {26'b0, mem_req, mem_we, mem_be}, 32'h0);
        check_output({tag, " mem_addr"}, mem_addr, 32'h0);
        check_output({tag, " mem_wdata"}, mem_wdata, 32'h0);
        check_output({tag, " hit_cnt"}, hit_cnt, 32'h0);
        check_output({tag, " miss_cnt"}, miss_cnt, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 32'h0;
        cpu_wdata = 32'h0;
        cpu_be = 4'h0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, then hit in the same line.
        expect_refill(32'h40);
        apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h11, 10);
        check_counters(0, 1);
        apply_stimulus(1'b0, 32'h48, 32'h0, 4'h0, 32'h33, 1);
        check_counters(1, 1);

        // Partial store hit merges into the cached word.
        apply_stimulus(1'b1, 32'h44, 32'hAABBCCDD, 4'b0011, 32'h0, 3);
        apply_stimulus(1'b0, 32'h44, 32'h0, 4'h0, 32'h0000CCDD, 1);
        check_counters(2, 1);

        // Store miss does not allocate; the following load refills.
        apply_stimulus(1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 3);
        expect_refill(32'h1000);
        apply_stimulus(1'b0, 32'h1000, 32'h0, 4'h0, 32'h12345678, 10);
        apply_stimulus(1'b0, 32'h1008, 32'h0, 4'h0, 32'hD0001008, 1);
        check_counters(3, 2);

        // Zero byte-enable store still goes to memory but leaves the word alone.
        apply_stimulus(1'b1, 32'h48, 32'hFFFFFFFF, 4'h0, 32'h0, 3);
        apply_stimulus(1'b0, 32'h48, 32'h0, 4'h0, 32'h33, 1);

        // Store to a line the cycle after its refill response hits.
        expect_refill(32'h80);
        apply_stimulus(1'b0, 32'h80, 32'h0, 4'h0, 32'hD0000080, 10);
        apply_stimulus(1'b1, 32'h84, 32'h00000055, 4'hF, 32'h0, 3);
        apply_stimulus(1'b0, 32'h84, 32'h0, 4'h0, 32'h00000055, 1);
        check_counters(5, 3);

        // Reset after the second refill word of index 4 aborts the refill.
        mem_q.push_back('{1'b0, 32'h840, 32'h0, 4'h0});
        mem_q.push_back('{1'b0, 32'h844, 32'h0, 4'h0});
        base = ack_count;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h840;
        n = 0;
        while (ack_count < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("acks before reset", 32'(ack_count - base), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        check_reset_outputs("mid-refill reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_refill(32'h840);
        apply_stimulus(1'b0, 32'h840, 32'h0, 4'h0, 32'hD0000840, 10);
        check_counters(0, 1);

        // Same index, different tags: eviction forces a second miss on 0x040.
        expect_refill(32'h40);
        apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h11, 10);
        expect_refill(32'h440);
        apply_stimulus(1'b0, 32'h440, 32'h0, 4'h0, 32'hD0000440, 10);
        expect_refill(32'h40);
        apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h11, 10);
        check_counters(0, 4);

        // Back-to-back hits, one per cycle.
        apply_stimulus(1'b0, 32'h44, 32'h0, 4'h0, 32'h0000CCDD, 1);
        apply_stimulus(1'b0, 32'h48, 32'h0, 4'h0, 32'h33, 1);
        apply_stimulus(1'b0, 32'h4C, 32'h0, 4'h0, 32'h44, 1);
        check_counters(3, 4);

        repeat (5) @(posedge clk);
        #1;
        check_output("cpu expectations left", 32'(cpu_q.size()), 32'h0);
        check_output("mem expectations left", 32'(mem_q.size()), 32'h0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
